control_mc: RTL and testbench
=============================

CONTROL_MC -- requirements
Module: control_mc

Interface
REQ-001 Parameter MEM_HS, default 1, meaning 1 = wait on imem_ready/dmem_ready, 0 = memories treated as always ready.
REQ-002 Parameter WDT_W, default 4, meaning memory-wait watchdog counter width; limit WDT_MAX = 2^WDT_W-1 cycles.
REQ-003 Parameter CNT_W, default 16, meaning width of retired-instruction counter.
REQ-004 clk  in  1  rising-edge clock, the only clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 run  in  1  start/continue execution.
REQ-007 opcode  in  3  IR[15:13]: ADD 000, ADDI 001, NAND 010, LUI 011, SW 100, LW 101, BEQ 110, JALR 111.
REQ-008 eq  in  1  register comparison rA==rB.
REQ-009 imm_nz  in  1  IR immediate field nonzero; JALR with imm_nz=1 is HALT.
REQ-010 imem_ready, dmem_ready  in  1 each  memory completion strobes.
REQ-011 func_alu  out  2  00 add, 01 nand, 10 pass src1, 11 reserved.
REQ-012 mux_alu1  out  1  0 RF port 1, 1 imm10<<6.
REQ-013 mux_alu2  out  1  0 RF port 2, 1 sign-extended imm7.
REQ-014 mux_pc  out  2  00 pc+1, 01 pc+1+imm7, 10 RF port 1 (JALR).
REQ-015 mux_rf  out  1  RF port 2 address: 0 rC, 1 rA.
REQ-016 mux_tgt  out  2  RF write data: 00 ALU, 01 dmem, 10 pc+1.
REQ-017 we_rf, we_dmem, we_pc, we_ir  out  1 each  write enables.
REQ-018 imem_req, dmem_req  out  1 each  memory requests.
REQ-019 state  out  3  current state encoding; halted, fault  out  1 each; retired  out  CNT_W.

Function
REQ-020 States and encodings: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6, FAULT 7; all outputs registered-state decoded, no combinational path from run to outputs.
REQ-021 IDLE: run=1 -> FETCH next cycle; otherwise stay.
REQ-022 FETCH: imem_req=1; on ready (imem_ready, or every cycle when MEM_HS=0) we_ir=1 same cycle, -> DECODE.
REQ-023 DECODE: one cycle, no enables, -> EXEC.
REQ-024 EXEC ADD/NAND: func_alu per op, mux_alu2=0 -> WB; ADDI: func 00, mux_alu2=1 -> WB; LUI: func 10, mux_alu1=1 -> WB.
REQ-025 EXEC SW/LW: func 00, mux_alu2=1 -> MEM; SW also sets mux_rf=1.
REQ-026 EXEC BEQ: mux_rf=1, we_pc=1, mux_pc=01 if eq else 00, retire.
REQ-027 EXEC JALR, imm_nz=0: we_rf=1, mux_tgt=10, we_pc=1, mux_pc=10, retire; imm_nz=1: no writes, -> HALT.
REQ-028 MEM: dmem_req=1 held; SW holds we_dmem=1; on ready SW retires with we_pc=1, mux_pc=00; LW -> WB with mux_tgt=01 latched.
REQ-029 WB: we_rf=1, mux_tgt 00 (ALU ops) or 01 (LW), we_pc=1, mux_pc=00, retire.
REQ-030 Retire: retired increments by 1, wrapping at 2^CNT_W; next state FETCH if run=1, else IDLE.
REQ-031 Watchdog: counter clears on entry to FETCH/MEM, increments each not-ready cycle; reaching WDT_MAX -> FAULT; ready in the same cycle wins (no fault). Disabled when MEM_HS=0.
REQ-032 HALT and FAULT are sticky until rst; halted=1 in HALT, fault=1 in FAULT; all enables and requests 0 there.
REQ-033 Signals not named for a state are 0.

Reset
REQ-034 rst=1 forces IDLE, retired=0, watchdog=0, all enables/requests/muxes/func_alu=0, halted=fault=0, immediately and regardless of clk, including mid-MEM (we_dmem drops at once).
REQ-035 After rst falls, first transition occurs on the next rising clk with run=1.

Verification
REQ-036 MEM_HS=1, ADD with ready asserted at once -> states 1,2,3,5 then 1; we_rf=1,we_pc=1 in WB; retired=1.
REQ-037 LW, dmem_ready after 3 wait cycles -> MEM held 4 cycles with dmem_req=1, then WB mux_tgt=01; no fault.
REQ-038 BEQ eq=1 -> EXEC mux_pc=01, we_pc=1; eq=0 -> mux_pc=00; both retire without WB.
REQ-039 JALR imm_nz=1 -> HALT (6), halted=1, retired unchanged, stays after 20 cycles of run=1.
REQ-040 WDT_W=4, imem_ready held 0 -> FAULT after 15 FETCH cycles; ready on cycle 15 -> DECODE instead.
REQ-041 rst pulse mid-MEM of SW -> we_dmem, dmem_req 0 before next clk edge, state 0, retired 0; CNT_W=2 after 4 retires -> retired=0.

Source files
------------

// File: rtl/control_mc.sv
// Multicycle control FSM for a 16-bit, 8-opcode core. It sequences fetch,
// decode, execute, memory and writeback, and adds a memory-wait watchdog and a retired-instruction counter.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction memory request, IR load on ready
// DECODE | one-cycle register read slot
// EXEC   | ALU/branch/jump; branches and JALR retire here
// MEM    | data memory access, SW retires here
// WB     | register write for ALU ops and LW
// HALT   | sticky stop after JALR with nonzero immediate
// FAULT  | sticky stop after a memory wait timeout
module control_mc #(
  parameter int MEM_HS = 1,
  parameter int WDT_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             eq,
  input  logic             imm_nz,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic [1:0]       func_alu,
  output logic             mux_alu1,
  output logic             mux_alu2,
  output logic [1:0]       mux_pc,
  output logic             mux_rf,
  output logic [1:0]       mux_tgt,
  output logic             we_rf,
  output logic             we_dmem,
  output logic             we_pc,
  output logic             we_ir,
  output logic             imem_req,
  output logic             dmem_req,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    FAULT  = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam logic [WDT_W-1:0] WDT_MAX = '1;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WDT_W-1:0] wdt_q;
  logic             imem_rdy, dmem_rdy, wdt_hit, retire;

  assign imem_rdy = (MEM_HS != 0) ? imem_ready : 1'b1;
  assign dmem_rdy = (MEM_HS != 0) ? dmem_ready : 1'b1;
  // The cycle that would push the count to WDT_MAX is the one that faults.
  assign wdt_hit  = (MEM_HS != 0) && (wdt_q == WDT_MAX - WDT_W'(1));
  assign state    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      wdt_q   <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC) op_q <= opcode;
      if (retire) retired <= retired + CNT_W'(1);
      if (state_d != state_q && (state_d == FETCH || state_d == MEM))
        wdt_q <= '0;
      else if ((state_q == FETCH && !imem_rdy) || (state_q == MEM && !dmem_rdy))
        wdt_q <= wdt_q + WDT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    func_alu = 2'b00;
    mux_alu1 = 1'b0;
    mux_alu2 = 1'b0;
    mux_pc   = 2'b00;
    mux_rf   = 1'b0;
    mux_tgt  = 2'b00;
    we_rf    = 1'b0;
    we_dmem  = 1'b0;
    we_pc    = 1'b0;
    we_ir    = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          we_ir   = 1'b1;
          state_d = DECODE;
        end else if (wdt_hit) begin
          state_d = FAULT;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        case (opcode)
          OP_ADD:  state_d = WB;
          OP_NAND: begin func_alu = 2'b01; state_d = WB; end
          OP_ADDI: begin mux_alu2 = 1'b1; state_d = WB; end
          OP_LUI:  begin func_alu = 2'b10; mux_alu1 = 1'b1; state_d = WB; end
          OP_SW:   begin mux_alu2 = 1'b1; mux_rf = 1'b1; state_d = MEM; end
          OP_LW:   begin mux_alu2 = 1'b1; state_d = MEM; end
          OP_BEQ: begin
            mux_rf = 1'b1;
            we_pc  = 1'b1;
            mux_pc = eq ? 2'b01 : 2'b00;
            retire = 1'b1;
          end
          OP_JALR: begin
            if (imm_nz) begin
              state_d = HALT;
            end else begin
              we_rf   = 1'b1;
              mux_tgt = 2'b10;
              we_pc   = 1'b1;
              mux_pc  = 2'b10;
              retire  = 1'b1;
            end
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        we_dmem  = (op_q == OP_SW);
        if (dmem_rdy) begin
          if (op_q == OP_SW) begin
            we_pc  = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = WB;
          end
        end else if (wdt_hit) begin
          state_d = FAULT;
        end
      end
      WB: begin
        we_rf   = 1'b1;
        mux_tgt = (op_q == OP_LW) ? 2'b01 : 2'b00;
        we_pc   = 1'b1;
        retire  = 1'b1;
      end
      HALT:  halted = 1'b1;
      FAULT: fault  = 1'b1;
      default: state_d = IDLE;
    endcase
    if (retire) state_d = run ? FETCH : IDLE;
  end

endmodule

// File: tb/tb_control_mc.sv
// Directed bench for control_mc: instruction walk-throughs, branch/jump, halt,
// watchdog timeout and async reset, with hand-computed expectations.
module tb_control_mc;

  logic       clk = 1'b0;
  logic       rst, run, eq, imm_nz, imem_ready, dmem_ready;
  logic [2:0] opcode;
  logic [1:0] func_alu, mux_pc, mux_tgt;
  logic       mux_alu1, mux_alu2, mux_rf;
  logic       we_rf, we_dmem, we_pc, we_ir, imem_req, dmem_req, halted, fault;
  logic [2:0] state;
  logic [1:0] retired;

  int checks = 0;
  int failures = 0;

  control_mc #(.MEM_HS(1), .WDT_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .eq(eq), .imm_nz(imm_nz),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .func_alu(func_alu), .mux_alu1(mux_alu1), .mux_alu2(mux_alu2), .mux_pc(mux_pc),
    .mux_rf(mux_rf), .mux_tgt(mux_tgt), .we_rf(we_rf), .we_dmem(we_dmem),
    .we_pc(we_pc), .we_ir(we_ir), .imem_req(imem_req), .dmem_req(dmem_req),
    .state(state), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expects the DUT in FETCH with imem_ready=1; leaves it in EXEC.
  task automatic fd(input logic [2:0] op, input string tag);
    opcode = op;
    chk({tag, "_fetch_state"}, 16'(state), 16'd1);
    chk({tag, "_we_ir"}, 16'(we_ir), 16'd1);
    tick();
    chk({tag, "_decode_state"}, 16'(state), 16'd2);
    chk({tag, "_decode_we_pc"}, 16'(we_pc), 16'd0);
    tick();
    chk({tag, "_exec_state"}, 16'(state), 16'd3);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; opcode = 3'b000; eq = 1'b0; imm_nz = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    #12;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_retired", 16'(retired), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_fault", 16'(fault), 16'd0);
    chk("rst_imem_req", 16'(imem_req), 16'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    tick();
    chk("idle_no_run", 16'(state), 16'd0);
    run = 1'b1;
    tick();

    // ADD: 1,2,3,5 then 1
    fd(3'b000, "add");
    chk("add_func", 16'(func_alu), 16'd0);
    chk("add_alu2", 16'(mux_alu2), 16'd0);
    chk("add_exec_we_rf", 16'(we_rf), 16'd0);
    tick();
    chk("add_wb_state", 16'(state), 16'd5);
    chk("add_wb_we_rf", 16'(we_rf), 16'd1);
    chk("add_wb_we_pc", 16'(we_pc), 16'd1);
    chk("add_wb_tgt", 16'(mux_tgt), 16'd0);
    tick();
    chk("add_refetch", 16'(state), 16'd1);
    chk("add_retired", 16'(retired), 16'd1);

    // LW with 3 wait cycles
    fd(3'b101, "lw");
    chk("lw_alu2", 16'(mux_alu2), 16'd1);
    chk("lw_rf", 16'(mux_rf), 16'd0);
    tick();
    chk("lw_mem1_state", 16'(state), 16'd4);
    chk("lw_mem1_req", 16'(dmem_req), 16'd1);
    chk("lw_mem1_we_dmem", 16'(we_dmem), 16'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lw_mem_wait_state", 16'(state), 16'd4);
      chk("lw_mem_wait_req", 16'(dmem_req), 16'd1);
    end
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("lw_mem4_state", 16'(state), 16'd4);
    chk("lw_mem4_we_rf", 16'(we_rf), 16'd0);
    tick();
    dmem_ready = 1'b0;
    chk("lw_wb_state", 16'(state), 16'd5);
    chk("lw_wb_tgt", 16'(mux_tgt), 16'd1);
    chk("lw_wb_we_rf", 16'(we_rf), 16'd1);
    chk("lw_no_fault", 16'(fault), 16'd0);
    tick();
    chk("lw_retired", 16'(retired), 16'd2);

    // BEQ taken / not taken
    eq = 1'b1;
    fd(3'b110, "beq1");
    chk("beq1_pc", 16'(mux_pc), 16'd1);
    chk("beq1_we_pc", 16'(we_pc), 16'd1);
    chk("beq1_rf", 16'(mux_rf), 16'd1);
    chk("beq1_we_rf", 16'(we_rf), 16'd0);
    tick();
    chk("beq1_refetch", 16'(state), 16'd1);
    chk("beq1_retired", 16'(retired), 16'd3);
    eq = 1'b0;
    fd(3'b110, "beq0");
    chk("beq0_pc", 16'(mux_pc), 16'd0);
    chk("beq0_we_pc", 16'(we_pc), 16'd1);
    tick();
    chk("beq0_refetch", 16'(state), 16'd1);
    chk("beq0_retired_wrap", 16'(retired), 16'd0);

    // ADDI, LUI, NAND
    fd(3'b001, "addi");
    chk("addi_func", 16'(func_alu), 16'd0);
    chk("addi_alu2", 16'(mux_alu2), 16'd1);
    chk("addi_alu1", 16'(mux_alu1), 16'd0);
    tick();
    chk("addi_wb", 16'(state), 16'd5);
    tick();
    chk("addi_retired", 16'(retired), 16'd1);
    fd(3'b011, "lui");
    chk("lui_func", 16'(func_alu), 16'd2);
    chk("lui_alu1", 16'(mux_alu1), 16'd1);
    chk("lui_alu2", 16'(mux_alu2), 16'd0);
    tick();
    tick();
    chk("lui_retired", 16'(retired), 16'd2);
    fd(3'b010, "nand");
    chk("nand_func", 16'(func_alu), 16'd1);
    chk("nand_alu2", 16'(mux_alu2), 16'd0);
    tick();
    tick();
    chk("nand_retired", 16'(retired), 16'd3);

    // JALR link/jump
    fd(3'b111, "jalr");
    chk("jalr_we_rf", 16'(we_rf), 16'd1);
    chk("jalr_tgt", 16'(mux_tgt), 16'd2);
    chk("jalr_we_pc", 16'(we_pc), 16'd1);
    chk("jalr_pc", 16'(mux_pc), 16'd2);
    tick();
    chk("jalr_refetch", 16'(state), 16'd1);
    chk("jalr_retired", 16'(retired), 16'd0);

    // SW completing at once, run dropped -> IDLE
    fd(3'b100, "sw");
    chk("sw_rf", 16'(mux_rf), 16'd1);
    chk("sw_alu2", 16'(mux_alu2), 16'd1);
    dmem_ready = 1'b1;
    tick();
    run = 1'b0;
    chk("sw_mem_state", 16'(state), 16'd4);
    chk("sw_we_dmem", 16'(we_dmem), 16'd1);
    chk("sw_we_pc", 16'(we_pc), 16'd1);
    chk("sw_pc", 16'(mux_pc), 16'd0);
    tick();
    chk("sw_to_idle", 16'(state), 16'd0);
    chk("sw_retired", 16'(retired), 16'd1);

    // SW interrupted by reset mid-MEM
    run = 1'b1;
    dmem_ready = 1'b0;
    tick();
    fd(3'b100, "sw_rst");
    tick();
    chk("swr_we_dmem", 16'(we_dmem), 16'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("swr_rst_we_dmem", 16'(we_dmem), 16'd0);
    chk("swr_rst_req", 16'(dmem_req), 16'd0);
    chk("swr_rst_state", 16'(state), 16'd0);
    chk("swr_rst_retired", 16'(retired), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_fetch", 16'(state), 16'd1);

    // JALR with nonzero immediate -> HALT
    imm_nz = 1'b1;
    fd(3'b111, "halt");
    chk("halt_exec_we_rf", 16'(we_rf), 16'd0);
    chk("halt_exec_we_pc", 16'(we_pc), 16'd0);
    tick();
    chk("halt_state", 16'(state), 16'd6);
    chk("halt_flag", 16'(halted), 16'd1);
    repeat (20) tick();
    chk("halt_sticky", 16'(state), 16'd6);
    chk("halt_flag_sticky", 16'(halted), 16'd1);
    chk("halt_imem_req", 16'(imem_req), 16'd0);
    chk("halt_retired", 16'(retired), 16'd0);

    // Fetch watchdog timeout
    rst = 1'b1;
    imm_nz = 1'b0;
    imem_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("wdt_fetch1", 16'(state), 16'd1);
    chk("wdt_fetch1_req", 16'(imem_req), 16'd1);
    for (int i = 2; i <= 15; i++) begin
      tick();
      chk("wdt_fetch_hold", 16'(state), 16'd1);
    end
    tick();
    chk("wdt_fault_state", 16'(state), 16'd7);
    chk("wdt_fault_flag", 16'(fault), 16'd1);
    chk("wdt_fault_req", 16'(imem_req), 16'd0);
    imem_ready = 1'b1;
    repeat (3) tick();
    chk("wdt_fault_sticky", 16'(state), 16'd7);

    // Ready on the 15th cycle wins over the timeout
    rst = 1'b1;
    imem_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    repeat (13) tick();
    chk("wdt_c14_state", 16'(state), 16'd1);
    tick();
    imem_ready = 1'b1;
    #1;
    chk("wdt_c15_state", 16'(state), 16'd1);
    chk("wdt_c15_we_ir", 16'(we_ir), 16'd1);
    tick();
    chk("wdt_late_decode", 16'(state), 16'd2);
    chk("wdt_late_no_fault", 16'(fault), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
